// File: rtl/freq_meter.sv
// -----------------------------------------------------------------------------
// freq_meter
//   Gated edge-counting frequency meter. Counts rising edges of an
//   asynchronous input over a fixed gate of GATE_CYCLES reference clocks.
//   The gate is aligned to the first synchronized rising edge after start
//   (that edge itself is not counted). Host computes
//   f_in = freq_count * CLK_HZ / GATE_CYCLES.
//
//   Optional feature macro: FREQ_METER_PERIOD_EN
//     When defined, adds period_cyc: the last full sig_in period seen inside
//     the gate, measured in clk cycles (0 if no full period fit in the gate).
//
// Parameters
//   CLK_HZ       reference clock frequency (documentation/scaling only)
//   GATE_CYCLES  gate length in clk cycles, >= 2
//   CNT_W        width of edge counter / freq_count / period_cyc
//   SYNC_STAGES  synchronizer depth on sig_in, >= 2
//
// Ports
//   clk         in   reference clock, rising edge
//   rst         in   asynchronous active-low reset
//   sig_in      in   measured signal, asynchronous to clk
//   start       in   1-cycle measurement request (ignored while busy)
//   busy        out  high from accepted start through the meas_valid cycle
//   meas_valid  out  1-cycle pulse when results update
//   freq_count  out  edges counted in the last gate (saturating), held
//   no_sig      out  last measurement saw no arming edge, held
//   ovf         out  last measurement saturated freq_count, held
//   period_cyc  out  (FREQ_METER_PERIOD_EN only) last full period in clk cycles
// -----------------------------------------------------------------------------
module freq_meter #(
  parameter int CLK_HZ      = 100_000_000,
  parameter int GATE_CYCLES = 100_000,
  parameter int CNT_W       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  input  logic             start,
  output logic             busy,
  output logic             meas_valid,
  output logic [CNT_W-1:0] freq_count,
  output logic             no_sig,
  output logic             ovf
`ifdef FREQ_METER_PERIOD_EN
  ,
  output logic [CNT_W-1:0] period_cyc
`endif
);

  if (GATE_CYCLES < 2 || SYNC_STAGES < 2 || CNT_W < 2 || CLK_HZ <= 0) begin : g_bad_cfg
    $error("freq_meter: invalid parameter set");
  end

  localparam int TW = $clog2(GATE_CYCLES + 1);
  localparam logic [TW-1:0]    TMR_LAST = TW'(GATE_CYCLES - 1);
  localparam logic [TW-1:0]    TMR_ONE  = {{(TW-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_GATE = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t                 state_r;
  logic [SYNC_STAGES-1:0] sync_r;
  logic                   prev_r;
  logic                   rise_s;
  // timer_r: cycles already spent in the current ARM wait or gate
  logic [TW-1:0]          timer_r;
  logic [CNT_W-1:0]       cnt_r;
  logic                   ovf_acc_r;
  logic [CNT_W-1:0]       cnt_nxt_s;
  logic                   ovf_nxt_s;

  // Synchronizer chain and edge register on the asynchronous input
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_r <= '0;
      prev_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], sig_in};
      prev_r <= sync_r[SYNC_STAGES-1];
    end
  end

  assign rise_s = sync_r[SYNC_STAGES-1] & ~prev_r;

  // Next edge count including a rise in the current gate cycle (saturating)
  always_comb begin
    cnt_nxt_s = cnt_r;
    ovf_nxt_s = ovf_acc_r;
    if (state_r == ST_GATE && rise_s) begin
      if (cnt_r == CNT_MAX) begin
        ovf_nxt_s = 1'b1;
      end else begin
        cnt_nxt_s = cnt_r + CNT_ONE;
      end
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Measurement FSM; results are latched on the edge entering DONE so that
  // meas_valid and the new values appear together during the DONE cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      timer_r    <= '0;
      cnt_r      <= '0;
      ovf_acc_r  <= 1'b0;
      busy       <= 1'b0;
      meas_valid <= 1'b0;
      freq_count <= '0;
      no_sig     <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          meas_valid <= 1'b0;
          if (start) begin
            state_r   <= ST_ARM;
            busy      <= 1'b1;
            timer_r   <= '0;
            cnt_r     <= '0;
            ovf_acc_r <= 1'b0;
          end
        end
        ST_ARM: begin
          if (rise_s) begin
            // Arming edge aligns the gate and is not counted
            state_r <= ST_GATE;
            timer_r <= '0;
          end else if (timer_r == TMR_LAST) begin
            state_r    <= ST_DONE;
            meas_valid <= 1'b1;
            freq_count <= '0;
            no_sig     <= 1'b1;
            ovf        <= 1'b0;
          end else begin
            timer_r <= timer_r + TMR_ONE;
          end
        end
        ST_GATE: begin
          cnt_r     <= cnt_nxt_s;
          ovf_acc_r <= ovf_nxt_s;
          if (timer_r == TMR_LAST) begin
            // Final gate cycle: its rise is already folded into cnt_nxt_s
            state_r    <= ST_DONE;
            meas_valid <= 1'b1;
            freq_count <= cnt_nxt_s;
            no_sig     <= 1'b0;
            ovf        <= ovf_nxt_s;
          end else begin
            timer_r <= timer_r + TMR_ONE;
          end
        end
        ST_DONE: begin
          state_r    <= ST_IDLE;
          meas_valid <= 1'b0;
          busy       <= 1'b0;
        end
        default: begin
          state_r    <= ST_IDLE;
          meas_valid <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

`ifdef FREQ_METER_PERIOD_EN
  logic [CNT_W-1:0] per_cnt_r;
  logic [CNT_W-1:0] per_cap_r;
  logic [CNT_W-1:0] per_cap_nxt_s;
  logic             done_go_s;

  // Capture on a gate rise: counter holds cycles since the previous rise
  // minus one (it restarts at 0 the cycle after a rise), so add one back
  always_comb begin
    per_cap_nxt_s = per_cap_r;
    if (state_r == ST_GATE && rise_s) begin
      if (per_cnt_r == CNT_MAX) begin
        per_cap_nxt_s = CNT_MAX;
      end else begin
        per_cap_nxt_s = per_cnt_r + CNT_ONE;
      end
    end else begin
      per_cap_nxt_s = per_cap_r;
    end
  end

  // Edge that moves the FSM into DONE
  always_comb begin
    done_go_s = 1'b0;
    if (state_r == ST_ARM) begin
      done_go_s = ~rise_s & (timer_r == TMR_LAST);
    end else if (state_r == ST_GATE) begin
      done_go_s = (timer_r == TMR_LAST);
    end else begin
      done_go_s = 1'b0;
    end
  end

  // Free-running saturating period counter, restarted by rises in ARM/GATE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      per_cnt_r <= '0;
    end else if (rise_s && (state_r == ST_ARM || state_r == ST_GATE)) begin
      per_cnt_r <= '0;
    end else if (per_cnt_r != CNT_MAX) begin
      per_cnt_r <= per_cnt_r + CNT_ONE;
    end
  end

  // Last captured period, cleared when a new measurement is accepted
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      per_cap_r <= '0;
    end else if (state_r == ST_IDLE && start) begin
      per_cap_r <= '0;
    end else begin
      per_cap_r <= per_cap_nxt_s;
    end
  end

  // Registered period output, updated together with meas_valid
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      period_cyc <= '0;
    end else if (done_go_s) begin
      period_cyc <= per_cap_nxt_s;
    end
  end
`endif

endmodule
